// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it to the register file and counts retired writes.
// Optional build macro WB_BYPASS_EN adds a write-first bypass on read ports qa/qb (dbg_q is never bypassed).
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [DW-1:0] wb_result,
    input  logic [DW-1:0] wb_mo,
    input  logic          wb_m2reg,
    input  logic          wb_wreg,
    input  logic [AW-1:0] wb_rn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic [AW-1:0] dbg_rn,
    output logic [DW-1:0] dbg_q,
    output logic [DW-1:0] wb_data,
    output logic [31:0]   wb_count
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs [NREG];
    logic [31:0]   count_q;
    logic          commit;
    logic [DW-1:0] qa_stored;
    logic [DW-1:0] qb_stored;

    assign wb_data = wb_m2reg ? wb_mo : wb_result;
    assign commit  = wb_wreg && (wb_rn != '0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            count_q <= '0;
        end else if (commit) begin
            regs[wb_rn] <= wb_data;
            count_q     <= count_q + 32'd1;
        end
    end

    // Register 0 is forced to zero on read rather than relying on it never being written.
    always_comb begin
        qa_stored = '0;
        qb_stored = '0;
        dbg_q     = '0;
        if (rna != '0) begin
            qa_stored = regs[rna];
        end
        if (rnb != '0) begin
            qb_stored = regs[rnb];
        end
        if (dbg_rn != '0) begin
            dbg_q = regs[dbg_rn];
        end
    end

`ifdef WB_BYPASS_EN
    // commit already excludes register 0, so a bypass can never expose a write to r0.
    always_comb begin
        qa = qa_stored;
        qb = qb_stored;
        if (commit && (rna == wb_rn)) begin
            qa = wb_data;
        end
        if (commit && (rnb == wb_rn)) begin
            qb = wb_data;
        end
    end
`else
    assign qa = qa_stored;
    assign qb = qb_stored;
`endif

    assign wb_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations adapt to the WB_BYPASS_EN build.
module tb_wb_regfile;

    logic        clk;
    logic        clrn;
    logic [31:0] wb_result;
    logic [31:0] wb_mo;
    logic        wb_m2reg;
    logic        wb_wreg;
    logic [4:0]  wb_rn;
    logic [4:0]  rna;
    logic [4:0]  rnb;
    logic [31:0] qa;
    logic [31:0] qb;
    logic [4:0]  dbg_rn;
    logic [31:0] dbg_q;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int n_chk  = 0;
    int n_fail = 0;

    wb_regfile #(.DW(32), .AW(5)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .wb_result(wb_result),
        .wb_mo    (wb_mo),
        .wb_m2reg (wb_m2reg),
        .wb_wreg  (wb_wreg),
        .wb_rn    (wb_rn),
        .rna      (rna),
        .rnb      (rnb),
        .qa       (qa),
        .qb       (qb),
        .dbg_rn   (dbg_rn),
        .dbg_q    (dbg_q),
        .wb_data  (wb_data),
        .wb_count (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_same;

    initial begin
        clrn      = 1'b0;
        wb_result = '0;
        wb_mo     = '0;
        wb_m2reg  = 1'b0;
        wb_wreg   = 1'b0;
        wb_rn     = '0;
        rna       = '0;
        rnb       = '0;
        dbg_rn    = '0;

        // Reset state
        step();
        rna = 5'd3; rnb = 5'd31; dbg_rn = 5'd7;
        #1;
        chk("rst_qa", qa, 32'h0);
        chk("rst_qb", qb, 32'h0);
        chk("rst_dbg", dbg_q, 32'h0);
        chk("rst_count", wb_count, 32'h0);
        @(negedge clk);
        clrn = 1'b1;
        step();
        chk("wreg_known", {31'h0, $isunknown(wb_wreg)}, 32'h0);

        // Mux select = result, commit to r7
        wb_m2reg = 1'b0; wb_result = 32'hAAAA_0001; wb_mo = 32'h0000_5555;
        wb_rn = 5'd7; wb_wreg = 1'b1; rna = 5'd7;
        #1;
        chk("mux_result", wb_data, 32'hAAAA_0001);
        step();
        wb_wreg = 1'b0;
        #1;
        chk("r7_qa", qa, 32'hAAAA_0001);
        chk("count1", wb_count, 32'd1);

        // Mux select = memory data, commit to r8
        wb_m2reg = 1'b1; wb_rn = 5'd8; wb_wreg = 1'b1; rnb = 5'd8; dbg_rn = 5'd8;
        #1;
        chk("mux_mo", wb_data, 32'h0000_5555);
        step();
        wb_wreg = 1'b0;
        #1;
        chk("r8_qb", qb, 32'h0000_5555);
        chk("r8_dbg", dbg_q, 32'h0000_5555);
        chk("count2", wb_count, 32'd2);

        // Register 0 writes are discarded and never bypassed
        wb_m2reg = 1'b0; wb_result = 32'hFFFF_FFFF; wb_rn = 5'd0; wb_wreg = 1'b1;
        rna = 5'd0; rnb = 5'd0;
        #1;
        chk("r0_qa_pre", qa, 32'h0);
        chk("r0_qb_pre", qb, 32'h0);
        step();
        wb_wreg = 1'b0;
        #1;
        chk("r0_qa_post", qa, 32'h0);
        chk("r0_count", wb_count, 32'd2);

        // Same-cycle hazard on r5
        wb_result = 32'h11; wb_rn = 5'd5; wb_wreg = 1'b1;
        step();
        wb_result = 32'h22; rna = 5'd5; rnb = 5'd5; dbg_rn = 5'd5;
        #1;
`ifdef WB_BYPASS_EN
        exp_same = 32'h22;
`else
        exp_same = 32'h11;
`endif
        chk("haz_qa_pre", qa, exp_same);
        chk("haz_qb_pre", qb, exp_same);
        chk("haz_dbg_pre", dbg_q, 32'h11);
        chk("haz_count_pre", wb_count, 32'd3);
        step();
        wb_wreg = 1'b0;
        #1;
        chk("haz_qa_post", qa, 32'h22);
        chk("haz_qb_post", qb, 32'h22);
        chk("haz_dbg_post", dbg_q, 32'h22);
        chk("haz_count_post", wb_count, 32'd4);

        // Gated write to r9
        wb_result = 32'h0000_DEAD; wb_rn = 5'd9; wb_wreg = 1'b0; rna = 5'd9;
        step();
        #1;
        chk("gated_r9", qa, 32'h0);
        chk("gated_count", wb_count, 32'd4);

        // Asynchronous reset mid-cycle after writing r3
        wb_result = 32'h1234_5678; wb_rn = 5'd3; wb_wreg = 1'b1;
        step();
        wb_wreg = 1'b0; rna = 5'd3; rnb = 5'd7;
        #1;
        chk("r3_written", qa, 32'h1234_5678);
        #2;
        clrn = 1'b0;
        #1;
        chk("arst_qa", qa, 32'h0);
        chk("arst_qb", qb, 32'h0);
        chk("arst_count", wb_count, 32'h0);
        chk("arst_wb_data", wb_data, 32'h1234_5678);
        step();
        // Release mid-cycle with a commit pending on the first edge
        wb_result = 32'h0000_CAFE; wb_rn = 5'd10; wb_wreg = 1'b1; dbg_rn = 5'd10;
        #3;
        clrn = 1'b1;
        step();
        wb_wreg = 1'b0;
        #1;
        chk("post_rst_r3", qa, 32'h0);
        chk("post_rst_r7", qb, 32'h0);
        chk("first_edge_r10", dbg_q, 32'h0000_CAFE);
        chk("first_edge_count", wb_count, 32'd1);

        // Counter wrap
        dut.count_q = 32'hFFFF_FFFE;
        wb_result = 32'h0000_0B0B; wb_rn = 5'd11; wb_wreg = 1'b1;
        step();
        chk("wrap_ffff", wb_count, 32'hFFFF_FFFF);
        step();
        wb_wreg = 1'b0;
        #1;
        chk("wrap_zero", wb_count, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the pipeline: consumes the WB-stage fields registered at the MEM/WB boundary and commits them to the architectural register file.
- Selects the write data (ALU result or memory data), performs the write, and serves the two ID-stage read ports plus a debug read port.
- Keeps a retired-write counter for bring-up and test.

Parameters:
- DW, 32, data width of results, memory data and registers.
- AW, 5, register-number width; register count is 2**AW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  asynchronous, active-low reset.
- wb_result  in  DW  ALU result from MEM/WB.
- wb_mo  in  DW  memory read data from MEM/WB.
- wb_m2reg  in  1  1 selects wb_mo as write data, 0 selects wb_result.
- wb_wreg  in  1  register write enable from MEM/WB.
- wb_rn  in  AW  destination register number.
- rna  in  AW  ID read port A register number.
- rnb  in  AW  ID read port B register number.
- qa  out  DW  read data, port A.
- qb  out  DW  read data, port B.
- dbg_rn  in  AW  debug read register number.
- dbg_q  out  DW  debug read data; never bypassed.
- wb_data  out  DW  selected write-back value (combinational).
- wb_count  out  32  count of committed writes.

Behaviour:
- Reset: clk is the clock; clrn is asynchronous, active-low.
  - While clrn=0, all 2**AW registers and wb_count clear to 0 immediately, independent of clk.
  - qa, qb and dbg_q therefore read 0 during reset; wb_data still follows its inputs.
- Write-data select: wb_data = wb_m2reg ? wb_mo : wb_result. Pure mux, no latency.
- Commit condition: commit = wb_wreg && (wb_rn != 0).
  - On a rising clk edge with clrn=1 and commit=1, reg[wb_rn] <= wb_data.
  - Otherwise no register changes.
- Register 0:
  - Hardwired zero; writes to it are discarded.
  - Reads of register 0 return 0 on every port, including when a bypass would otherwise apply.
- Read ports: asynchronous (combinational) reads, qa = reg[rna], qb = reg[rnb], dbg_q = reg[dbg_rn]. Bypass behaviour is set by the optional feature below.
- Same-cycle read/write:
  - A read of the register being written returns the value defined by the bypass rule.
  - The stored value updates at the edge; the next cycle reads the new value on all ports.
- Both read ports may address the same register, with or without a pending write; each port resolves independently.
- wb_count:
  - Increments by 1 on each rising edge where commit=1.
  - 32-bit unsigned; wraps 0xFFFFFFFF -> 0x00000000 with no flag.
  - Writes to register 0 and cycles with wb_wreg=0 do not count.
- Reset released mid-stream:
  - The first rising edge after clrn rises to 1 commits normally if commit=1.
  - No state survives reset.
- Unknowns: X on wb_wreg is not allowed; the bench checks that it is never X after reset.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Write-first internal bypass on qa and qb.
  - If commit=1 and rna==wb_rn, qa = wb_data in the same cycle; the same rule applies to qb with rnb.
  - This resolves the WB->ID hazard without extra forwarding.
- Not defined:
  - qa and qb always return the stored value, so a same-cycle read sees the pre-write contents.
  - The ID-stage forwarding unit covers the hazard.
- dbg_q is never bypassed in either build.

Test Plan:
1. Reset: drive clrn=0 asynchronously mid-cycle after writing reg[3]=0x12345678 -> qa (rna=3) = 0 immediately and wb_count = 0; after release, reg[3] reads 0.
2. Mux and commit: wb_m2reg=0, wb_result=0xAAAA0001, wb_mo=0x5555, wb_rn=7, wb_wreg=1 for one edge -> next cycle qa(rna=7) = 0xAAAA0001 and wb_count=1. Repeat with wb_m2reg=1, wb_rn=8 -> reg[8] = 0x00005555 and wb_count=2.
3. Register 0: wb_wreg=1, wb_rn=0, wb_result=0xFFFFFFFF -> qa(rna=0) = 0 before and after the edge (also with WB_BYPASS_EN); wb_count is unchanged.
4. Same-cycle hazard: reg[5]=0x11, then write 0x22 to reg 5 with rna=rnb=5 in the same cycle.
   - With WB_BYPASS_EN: qa = qb = 0x22 before the edge.
   - Without it: qa = qb = 0x11 before the edge.
   - Both builds: 0x22 on the next cycle, and dbg_q(5) = 0x11 before the edge.
5. Gated write: wb_wreg=0, wb_rn=9, wb_result=0xDEAD -> reg[9] remains 0 and wb_count is unchanged.
6. Counter wrap: force wb_count to 0xFFFFFFFE via hierarchical deposit, then issue 2 commits -> 0xFFFFFFFF, then 0x00000000.
